mux41_scan_ctrl: RTL

- Upstream controller for the mux_41 4:1 multiplexer.
- Drives the mux select `s` through all four codes and samples the mux output `o` back after a programmable dwell.
- Reassembles the four sampled bits into a 4-bit word and hands it downstream over a valid/ready handshake.
- Used as a self-checking scan front-end: the captured word equals the mux data input `i` when the mux is correct.

---
 rtl/mux41_scan_ctrl_pkg.sv | 20 ++
 rtl/mux41_scan_ctrl_if.sv | 9 +
 rtl/mux41_scan_ctrl_dwell_timer.sv | 30 +++
 rtl/mux_41.sv | 8 +
 rtl/mux41_scan_ctrl.sv | 106 ++++++++++
 5 files changed

// File: rtl/mux41_scan_ctrl_pkg.sv
// Shared types and select-order tables for the mux_41 scan controller.
// Both step tables are indexed by step: entry k sits in bits [2k+1:2k].
package mux41_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        VALID
    } state_e;

    localparam logic [7:0] GRAY_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};
    localparam logic [7:0] BIN_SEQ  = {2'b11, 2'b10, 2'b01, 2'b00};

    function automatic logic [1:0] next_sel(input logic [1:0] step, input logic gray);
        logic [7:0] seq;
        seq = gray ? GRAY_SEQ : BIN_SEQ;
        return seq[{step, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/mux41_scan_ctrl_if.sv
// Word handoff bus between the scan controller and its downstream consumer.
interface mux41_scan_if;
    logic [3:0] word;
    logic       word_valid;
    logic       word_ready;

    modport master (output word, output word_valid, input word_ready);
    modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/mux41_scan_ctrl_dwell_timer.sv
// Dwell counter: counts while enabled, wraps at DWELL-1 and flags that cycle.
module mux41_dwell_timer #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mux_41.sv
// Plain 4:1 multiplexer driven by the scan controller: o = i[s].
module mux_41 (
    input  logic [3:0] i,
    input  logic [1:0] s,
    output logic       o
);
    assign o = i[s];
endmodule

// File: rtl/mux41_scan_ctrl.sv
// Scans mux_41 through all four select codes, captures o per code into a word
// and hands the word downstream over valid/ready. All outputs are registered.
module mux41_scan_ctrl
    import mux41_pkg::*;
#(
    parameter int unsigned DWELL = 2,
    parameter bit          GRAY  = 1'b1,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cont,
    output logic [1:0]         s,
    input  logic               o_in,
    output logic               busy,
    mux41_scan_if.master       bus
);
    state_e     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [1:0] s_q, s_d;
    logic [3:0] word_q, word_d;
    logic       word_valid_q, word_valid_d;
    logic       busy_q, busy_d;
    logic       tc;

    // Counter is held at zero outside SCAN, so every scan starts a fresh dwell.
    mux41_dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != SCAN),
        .en_i  (state_q == SCAN),
        .tc_o  (tc)
    );

    // NOTE: every _d gets its current value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        s_d          = s_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;

        unique case (state_q)
            IDLE: begin
                s_d = 2'b00;
                if (start) begin
                    state_d = SCAN;
                    step_d  = 2'd0;
                    word_d  = 4'b0000;
                end
            end
            SCAN: begin
                if (tc) begin
                    // Placement follows the select value, so the order does not matter.
                    word_d[s_q] = o_in;
                    if (step_q == 2'd3) begin
                        state_d      = VALID;
                        s_d          = 2'b00;
                        word_valid_d = 1'b1;
                    end else begin
                        step_d = step_q + 2'd1;
                        s_d    = next_sel(step_q + 2'd1, GRAY);
                    end
                end
            end
            VALID: begin
                if (bus.word_ready) begin
                    word_valid_d = 1'b0;
                    step_d       = 2'd0;
                    state_d      = cont ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_q       <= 2'd0;
            s_q          <= 2'b00;
            word_q       <= 4'b0000;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            s_q          <= s_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign s              = s_q;
    assign busy           = busy_q;
    assign bus.word       = word_q;
    assign bus.word_valid = word_valid_q;
endmodule
